mskand_hpc2_sched: RTL and testbench

Round-robin scheduler that shares one external HPC2 masked-AND gadget among `NREQ` requesters. It accepts share-encoded operand pairs, issues at most one operation per cycle, and presents operand A and fresh randomness at issue. It presents operand B one cycle later to match the gadget's input latency skew, then captures the gadget output two cycles after issue. Results return through a tagged, in-order result FIFO whose credit check guarantees that no in-flight result is ever dropped. The block sits between the masked S-box/round-logic requesters and the single shared gadget instance, with the PRNG feeding `rnd_in`.

---
 rtl/mskand_hpc2_sched.sv | 154 +++++++++++++++
 tb/tb_mskand_hpc2_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mskand_hpc2_sched.sv
// Round-robin scheduler sharing one HPC2 masked-AND gadget among NREQ
// requesters. A and randomness go out at issue, B one cycle later. The
// gadget result is captured two cycles after issue into an in-order tagged
// result FIFO. Shares are only routed and registered, never combined.
module mskand_hpc2_sched #(
  parameter  int d          = 2,
  parameter  int NREQ       = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int hpc2rnd    = d * (d - 1) / 2,
  localparam int IDW        = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*d-1:0]    req_a,
  input  logic [NREQ*d-1:0]    req_b,
  input  logic [hpc2rnd-1:0]   rnd_in,
  input  logic                 rnd_valid,
  output logic                 rnd_ready,
  output logic [d-1:0]         gad_ina,
  output logic [d-1:0]         gad_inb,
  output logic [hpc2rnd-1:0]   gad_rnd,
  input  logic [d-1:0]         gad_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDW-1:0]       res_id,
  output logic [d-1:0]         res_data
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;

  logic [IDW-1:0] last;
  logic [IDW-1:0] grant;
  logic           issue;
  logic [CW-1:0]  inflight;
  logic [d-1:0]   sel_b;

  logic           v1, v2;
  logic [IDW-1:0] id1, id2;
  logic [d-1:0]   b1;

  logic [PW:0]    count;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [IDW-1:0] mem_id   [FIFO_DEPTH];
  logic [d-1:0]   mem_data [FIFO_DEPTH];
  logic           push, pop;

  // Round-robin grant: lowest requester above 'last', else lowest overall.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) grant = IDW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (IDW'(i) > last)) grant = IDW'(i);
    end
  end

  // Credit check counts FIFO entries plus both in-flight stages; a same-cycle
  // pop is deliberately not credited.
  assign inflight = CW'(count) + CW'(v1) + CW'(v2);
  assign issue    = ~rst & (|req_valid) & rnd_valid & (inflight < CW'(FIFO_DEPTH));

  // Issue-side routing: grant handshakes plus A/randomness to the gadget.
  always_comb begin
    req_ready = '0;
    rnd_ready = 1'b0;
    gad_ina   = '0;
    gad_rnd   = '0;
    sel_b     = '0;
    if (issue) begin
      rnd_ready = 1'b1;
      gad_rnd   = rnd_in;
      for (int i = 0; i < NREQ; i++) begin
        if (grant == IDW'(i)) begin
          req_ready[i] = 1'b1;
          gad_ina      = req_a[i*d +: d];
          sel_b        = req_b[i*d +: d];
        end
      end
    end
  end

  assign gad_inb = v1 ? b1 : '0;

  // Round-robin pointer advances only on an actual issue.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= IDW'(NREQ - 1);
    end else if (issue) begin
      last <= grant;
    end
  end

  // Two-stage tracking pipeline: B is held for the gadget's one-cycle skew,
  // the requester tag follows the op until its result lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      id1 <= '0;
      id2 <= '0;
      b1  <= '0;
    end else begin
      v1 <= issue;
      if (issue) begin
        id1 <= grant;
        b1  <= sel_b;
      end
      v2  <= v1;
      id2 <= id1;
    end
  end

  assign push = v2;
  assign pop  = res_valid & res_ready;

  // Result FIFO: push the gadget output tagged with its requester, pop at head.
  // NOTE: storage is reset too so no share data from before reset stays visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_id[i]   <= '0;
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_id[wr_ptr]   <= id2;
        mem_data[wr_ptr] <= gad_out;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign res_valid = (count != '0);
  assign res_id    = res_valid ? mem_id[rd_ptr]   : '0;
  assign res_data  = res_valid ? mem_data[rd_ptr] : '0;

endmodule

// File: tb/tb_mskand_hpc2_sched.sv
// Self-checking bench for mskand_hpc2_sched: table of arbitration vectors,
// hand-written corner sequences and a randomized phase, all compared against
// a queue-based reference model and a behavioural gadget.
module tb_mskand_hpc2_sched;

  localparam int D     = 2;
  localparam int NREQ  = 4;
  localparam int DEPTH = 4;
  localparam int R     = 1;
  localparam int IDW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*D-1:0] req_a, req_b;
  logic [R-1:0]      rnd_in;
  logic              rnd_valid, rnd_ready;
  logic [D-1:0]      gad_ina, gad_inb, gad_out;
  logic [R-1:0]      gad_rnd;
  logic              res_valid, res_ready;
  logic [IDW-1:0]    res_id;
  logic [D-1:0]      res_data;

  mskand_hpc2_sched #(.d(D), .NREQ(NREQ), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .gad_ina(gad_ina), .gad_inb(gad_inb), .gad_rnd(gad_rnd), .gad_out(gad_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Behavioural gadget: A/rnd taken at issue, B one cycle later, output two
  // cycles after issue. Output sharing is (val ^ r, r), so XOR of shares = val.
  logic [D-1:0] g1_a = '0, g2_a = '0, g2_b = '0;
  logic [R-1:0] g1_r = '0, g2_r = '0;
  always @(posedge clk) begin
    g1_a <= gad_ina;
    g1_r <= gad_rnd;
    g2_a <= g1_a;
    g2_b <= gad_inb;
    g2_r <= g1_r;
  end
  assign gad_out = {g2_r[0], ((^g2_a) & (^g2_b)) ^ g2_r[0]};

  // Stimulus state (data changes only when the previous item was accepted).
  logic [NREQ-1:0] rv;
  logic [D-1:0]    a_d [NREQ];
  logic [D-1:0]    b_d [NREQ];
  logic [R-1:0]    rnd_d;
  logic            rndv, resr;

  // Reference model.
  typedef struct { int id; logic [D-1:0] b; logic [D-1:0] data; int cyc; } op_t;
  typedef struct { int id; logic [D-1:0] data; } res_t;
  op_t             infl[$];
  res_t            fifo_q[$];
  int              last_m, cyc, exp_grant;
  logic            exp_issue, rnd_acc;
  logic [NREQ-1:0] acc;

  int n_cmp = 0, n_err = 0;
  int n_issue_seen, n_pop_seen;

  typedef struct {
    logic [NREQ-1:0] rv;
    logic            rndv;
    logic [NREQ-1:0] exp_ready;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // Apply inputs, let them settle, and compare every output with the model.
  task automatic settle();
    logic [D-1:0]    exp_inb;
    logic [NREQ-1:0] exp_rdy;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*D +: D] = a_d[i];
      req_b[i*D +: D] = b_d[i];
    end
    rnd_in    = rnd_d;
    req_valid = rv;
    rnd_valid = rndv;
    res_ready = resr;
    #3;
    exp_issue = (rv != '0) && rndv && ((fifo_q.size() + infl.size()) < DEPTH);
    exp_grant = 0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (last_m + k) % NREQ;
      if (rv[j]) begin
        exp_grant = j;
        break;
      end
    end
    exp_rdy = exp_issue ? (NREQ'(1) << exp_grant) : '0;
    exp_inb = '0;
    foreach (infl[k]) if (infl[k].cyc == cyc - 1) exp_inb = infl[k].b;
    check("req_ready", req_ready, exp_rdy);
    check("rnd_ready", rnd_ready, exp_issue);
    check("gad_ina", gad_ina, exp_issue ? a_d[exp_grant] : '0);
    check("gad_rnd", gad_rnd, exp_issue ? rnd_d : '0);
    check("gad_inb", gad_inb, exp_inb);
    check("res_valid", res_valid, fifo_q.size() != 0);
    if (fifo_q.size() != 0) begin
      check("res_id", res_id, fifo_q[0].id);
      check("res_data", res_data, fifo_q[0].data);
    end
    n_issue_seen += int'(rnd_ready);
    n_pop_seen   += int'(res_valid & res_ready);
  endtask

  // Advance the model past the clock edge, then refresh consumed data.
  task automatic advance();
    op_t op;
    logic v;
    if (fifo_q.size() != 0 && resr) void'(fifo_q.pop_front());
    if (infl.size() != 0 && infl[0].cyc == cyc - 2) begin
      fifo_q.push_back('{id: infl[0].id, data: infl[0].data});
      void'(infl.pop_front());
    end
    acc     = '0;
    rnd_acc = 1'b0;
    if (exp_issue) begin
      v       = (^a_d[exp_grant]) & (^b_d[exp_grant]);
      op.id   = exp_grant;
      op.b    = b_d[exp_grant];
      op.data = {rnd_d[0], v ^ rnd_d[0]};
      op.cyc  = cyc;
      infl.push_back(op);
      last_m          = exp_grant;
      acc[exp_grant]  = 1'b1;
      rnd_acc         = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (!rv[i] || acc[i]) begin
        a_d[i] = D'($urandom);
        b_d[i] = D'($urandom);
      end
    end
    if (!rndv || rnd_acc) rnd_d = R'($urandom);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      settle();
      advance();
    end
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    #1;
    if (chk) begin
      check("rst_req_ready", req_ready, 0);
      check("rst_rnd_ready", rnd_ready, 0);
      check("rst_gad_ina", gad_ina, 0);
      check("rst_gad_inb", gad_inb, 0);
      check("rst_gad_rnd", gad_rnd, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_id", res_id, 0);
      check("rst_res_data", res_data, 0);
    end
    fifo_q.delete();
    infl.delete();
    last_m  = NREQ - 1;
    acc     = '0;
    rnd_acc = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Arbitration vectors starting from reset (last = 3), res_ready held high.
    tbl[0] = '{4'b1000, 1'b1, 4'b1000};
    tbl[1] = '{4'b1001, 1'b1, 4'b0001};
    tbl[2] = '{4'b1001, 1'b1, 4'b1000};
    tbl[3] = '{4'b1111, 1'b0, 4'b0000};
    tbl[4] = '{4'b1111, 1'b1, 4'b0001};
    tbl[5] = '{4'b1111, 1'b1, 4'b0010};
    tbl[6] = '{4'b0110, 1'b1, 4'b0100};
    tbl[7] = '{4'b0110, 1'b1, 4'b0010};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000};
    tbl[9] = '{4'b0101, 1'b1, 4'b0100};

    rst = 1'b0;
    rv = '0; rndv = 1'b0; resr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_d[i] = D'($urandom);
      b_d[i] = D'($urandom);
    end
    rnd_d = R'($urandom);
    cyc = 0; n_issue_seen = 0; n_pop_seen = 0;
    #2;
    do_reset(1'b1);

    // Table-driven arbitration.
    resr = 1'b1;
    for (int r = 0; r < 10; r++) begin
      rv   = tbl[r].rv;
      rndv = tbl[r].rndv;
      settle();
      check("tbl_grant", req_ready, tbl[r].exp_ready);
      advance();
    end
    rv = '0;
    cycles(4);

    // Single op from requester 2 with known shares.
    rv = 4'b0100; rndv = 1'b1; resr = 1'b1;
    a_d[2] = 2'b01; b_d[2] = 2'b01; rnd_d = 1'b1;
    settle();
    check("single_ready", req_ready, 4'b0100);
    check("single_ina", gad_ina, 2'b01);
    advance();
    rv = '0;
    settle();
    check("single_inb", gad_inb, 2'b01);
    advance();
    cycles(1);
    settle();
    check("single_valid", res_valid, 1);
    check("single_id", res_id, 2);
    check("single_xor", ^res_data, 1);
    advance();
    settle();
    check("single_popped", res_valid, 0);
    advance();

    // Continuous round robin from reset: grants 0,1,2,3,0,...
    do_reset(1'b0);
    rv = 4'b1111; rndv = 1'b1; resr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      settle();
      check("rr_grant", req_ready, 4'b0001 << (k % 4));
      advance();
    end
    rv = '0;
    cycles(4);

    // Randomness stall: no handshake while rnd_valid is low.
    rv = 4'b1111; rndv = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("stall_req_ready", req_ready, 0);
      check("stall_rnd_ready", rnd_ready, 0);
      advance();
    end
    rndv = 1'b1;
    settle();
    check("stall_resume", rnd_ready, 1);
    advance();
    rv = '0;
    cycles(4);

    // Backpressure: exactly DEPTH issues, then in-order drain.
    resr = 1'b0; rv = 4'b1111; rndv = 1'b1;
    n_issue_seen = 0;
    cycles(10);
    check("bp_issues", n_issue_seen, DEPTH);
    check("bp_full_valid", res_valid, 1);
    rv = '0; resr = 1'b1;
    n_pop_seen = 0;
    cycles(8);
    check("bp_pops", n_pop_seen, DEPTH);

    // Reset one cycle after two back-to-back issues.
    rv = 4'b1111; rndv = 1'b1; resr = 1'b1;
    cycles(2);
    rv = '0;
    settle();
    do_reset(1'b1);
    n_pop_seen = 0;
    cycles(5);
    check("rst_no_result", n_pop_seen, 0);
    rv = 4'b1111;
    settle();
    check("rst_next_grant", req_ready, 4'b0001);
    advance();
    rv = '0;
    cycles(4);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!(rv[i] && !acc[i])) rv[i] = ($urandom_range(0, 99) < 60);
      end
      if (!(rndv && !rnd_acc)) rndv = ($urandom_range(0, 99) < 80);
      resr = ($urandom_range(0, 99) < 60);
      settle();
      advance();
    end
    rv = '0; resr = 1'b1;
    cycles(8);
    check("final_empty", res_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
